// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch and data paths
// Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_dm
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} arbStateT;

  localparam logic [1:0] LAST_CNT = 2'(MEM_LAT - 1);

  if (MEM_LAT < 1 || MEM_LAT > 4 || STARVE_MAX < 1 || STARVE_MAX > 7) begin : gBadParam
    $error("mem_port_arbiter: MEM_LAT must be 1..4 and STARVE_MAX 1..7");
  end

  arbStateT    state, nextState;
  logic [1:0]  latCnt;
  logic        ownerDm;
  logic        issue, grantDm, capture, forceFetch;
  logic        ifValidQ, dmValidQ;
  logic [31:0] ifRdataQ, dmRdataQ;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [2:0] starveCnt;
  assign forceFetch = (starveCnt == 3'(STARVE_MAX));
`else
  assign forceFetch = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    issue     = 1'b0;
    grantDm   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          issue     = 1'b1;
          grantDm   = dm_req && !(if_req && forceFetch);
          nextState = WAIT;
        end
      end
      WAIT: begin
        if (latCnt == LAST_CNT) begin
          capture   = 1'b1;
          nextState = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Memory strobes are combinational from the IDLE grant so the issue costs no extra cycle.
  assign mem_en    = issue && !reset;
  assign mem_we    = mem_en && grantDm && dm_we;
  assign mem_addr  = grantDm ? dm_addr : if_addr;
  assign mem_wdata = grantDm ? dm_wdata : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      latCnt   <= 2'd0;
      ownerDm  <= 1'b0;
      ifValidQ <= 1'b0;
      dmValidQ <= 1'b0;
      ifRdataQ <= 32'h0;
      dmRdataQ <= 32'h0;
    end else begin
      ifValidQ <= capture && !ownerDm;
      dmValidQ <= capture && ownerDm;
      if (issue) begin
        ownerDm <= grantDm;
        latCnt  <= 2'd0;
      end else if (state == WAIT) begin
        latCnt <= latCnt + 2'd1;
      end
      if (capture) begin
        if (ownerDm) dmRdataQ <= mem_rdata;
        else         ifRdataQ <= mem_rdata;
      end
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  // Counts contested data wins; any fetch grant restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      starveCnt <= 3'd0;
    end else if (issue) begin
      if (!grantDm)    starveCnt <= 3'd0;
      else if (if_req) starveCnt <= starveCnt + 3'd1;
    end
  end
`endif

  // An in-flight access hit by reset must not signal completion.
  assign if_valid = ifValidQ && !reset;
  assign dm_valid = dmValidQ && !reset;
  assign if_rdata = ifRdataQ;
  assign dm_rdata = dmRdataQ;
  assign stall_if = if_req && !if_valid && !reset;
  assign stall_dm = dm_req && !dm_valid && !reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized testbench with transaction-level reference model
module tb_mem_port_arbiter;

  localparam int LAT    = 2;
  localparam int STARVE = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_valid, dm_valid, mem_en, mem_we, stall_if, stall_dm;

  int nCmp = 0;
  int nFail = 0;

  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_dm(stall_dm)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(int i);
    return (i == 4) ? 32'h00500093 : ((32'(i) * 32'h9E3779B1) ^ 32'h13579BDF);
  endfunction

  // Memory: read-first array with a LAT-deep return pipe; idle slots carry noise.
  logic [31:0] memArr [64];
  logic [31:0] rdPipe [LAT];
  bit          memReady;

  always @(posedge clk) begin
    if (!memReady) begin
      for (int i = 0; i < 64; i++) memArr[i] <= initWord(i);
      memReady <= 1'b1;
    end else if (mem_en && mem_we) begin
      memArr[mem_addr[7:2]] <= mem_wdata;
    end
    rdPipe[0] <= (mem_en && memReady) ? memArr[mem_addr[7:2]] : $urandom;
    for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign mem_rdata = rdPipe[LAT-1];

  int cyc = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: one transaction at a time, busy for LAT+2 cycles from issue.
  logic [31:0] modelMem [64];
  bit          mInit;
  int          freeAt = 0, validAt = 0, starve = 0;
  bit          pend, pendDm;
  logic [31:0] pendData, expIfR, expDmR, a;
  bit          eEn, winDm, eIfV, eDmV;

  always @(negedge clk) begin
    if (!mInit) begin
      for (int i = 0; i < 64; i++) modelMem[i] = initWord(i);
      mInit = 1'b1;
    end
    if (pend && cyc == validAt) begin
      if (pendDm) expDmR = pendData;
      else        expIfR = pendData;
    end
    eIfV  = !reset && pend && cyc == validAt && !pendDm;
    eDmV  = !reset && pend && cyc == validAt && pendDm;
    eEn   = 1'b0;
    winDm = 1'b0;
    if (!reset && cyc >= freeAt && (if_req || dm_req)) begin
      eEn   = 1'b1;
      winDm = dm_req;
`ifdef MEM_ARB_STARVE_GUARD_EN
      if (if_req && dm_req && starve == STARVE) winDm = 1'b0;
`endif
    end
    a = winDm ? dm_addr : if_addr;
    if (cyc > 0) begin
      chk("mem_en", mem_en, eEn);
      chk("if_valid", if_valid, eIfV);
      chk("dm_valid", dm_valid, eDmV);
      chk("stall_if", stall_if, !reset && if_req && !eIfV);
      chk("stall_dm", stall_dm, !reset && dm_req && !eDmV);
      chk("if_rdata", if_rdata, expIfR);
      chk("dm_rdata", dm_rdata, expDmR);
      if (reset) chk("mem_we_rst", mem_we, 0);
      if (eEn) begin
        chk("mem_addr", mem_addr, a);
        chk("mem_we", mem_we, winDm && dm_we);
        chk("mem_wdata", mem_wdata, winDm ? dm_wdata : 32'h0);
      end
    end
    if (pend && cyc == validAt) pend = 1'b0;
    if (reset) begin
      pend   = 1'b0;
      expIfR = 32'h0;
      expDmR = 32'h0;
      freeAt = cyc + 1;
      starve = 0;
    end else if (eEn) begin
      pend     = 1'b1;
      pendDm   = winDm;
      pendData = modelMem[a[7:2]];
      validAt  = cyc + LAT + 1;
      freeAt   = cyc + LAT + 2;
      if (winDm && dm_we) modelMem[a[7:2]] = dm_wdata;
      if (!winDm)      starve = 0;
      else if (if_req) starve = starve + 1;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int weCnt, got, grants, firstFetch, lastIssue;
    bit seenIf, seenDm;
    reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    chk("rst_if_valid", if_valid, 1'b0);

    // Fetch only from 0x10
    step(); if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk); chk("f_issue_en", mem_en, 1); chk("f_issue_addr", mem_addr, 32'h10);
    chk("f_stall_t", stall_if, 1);
    @(negedge clk); chk("f_stall_t1", stall_if, 1);
    @(negedge clk); chk("f_stall_t2", stall_if, 1); chk("f_novalid_t2", if_valid, 0);
    @(negedge clk); chk("f_valid_t3", if_valid, 1); chk("f_rdata_t3", if_rdata, 32'h00500093);
    chk("f_stall_t3", stall_if, 0);
    step(); if_req = 1'b0;

    // Simultaneous fetch and data load: data first
    step(); if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    @(negedge clk); chk("c_dm_addr", mem_addr, 32'h40); chk("c_dm_we", mem_we, 0);
    repeat (2) @(negedge clk);
    @(negedge clk); chk("c_dm_valid_t3", dm_valid, 1); chk("c_if_wait_t3", if_valid, 0);
    step(); dm_req = 1'b0;
    @(negedge clk); chk("c_if_issue_t4", mem_en, 1); chk("c_if_addr_t4", mem_addr, 32'h20);
    repeat (2) @(negedge clk);
    @(negedge clk); chk("c_if_valid_t7", if_valid, 1);
    step(); if_req = 1'b0;

    // Store then load at 0x40
    step(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
    weCnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      weCnt += int'(mem_we);
    end
    chk("s_we_cycles", weCnt, 1);
    chk("s_dm_valid", dm_valid, 1);
    step(); dm_we = 1'b0;
    repeat (4) @(negedge clk);
    chk("l_dm_valid", dm_valid, 1); chk("l_dm_rdata", dm_rdata, 32'hDEADBEEF);
    step(); dm_req = 1'b0;

    // Continuous data requests with fetch pending
    step(); if_req = 1'b1; if_addr = 32'h80; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
    grants = 0; firstFetch = 0; lastIssue = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (mem_en) begin
        grants++;
        if (mem_addr == 32'h80 && firstFetch == 0) firstFetch = grants;
        if (lastIssue >= 0) chk("issue_spacing", k - lastIssue, LAT + 2);
        lastIssue = k;
      end
      seenIf = if_valid;
      step();
      if (seenIf) if_req = 1'b0;
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("starve_fetch_grant_idx", firstFetch, 4);
`else
    chk("starve_no_fetch", firstFetch, 0);
`endif
    if_req = 1'b0; dm_req = 1'b0;
    repeat (6) step();

    // Reset during the second WAIT cycle
    if_req = 1'b1; if_addr = 32'h14;
    @(negedge clk); chk("r_issue", mem_en, 1);
    step();
    step(); reset = 1'b1;
    @(negedge clk); chk("r_mem_en_rst", mem_en, 0); chk("r_stall_rst", stall_if, 0);
    chk("r_valid_rst", if_valid, 0);
    step(); reset = 1'b0;
    @(negedge clk); chk("r_reissue", mem_en, 1); chk("r_no_old_valid", if_valid, 0);
    got = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (if_valid) begin
        got = k;
        break;
      end
    end
    chk("r_reissue_valid_delay", got, 3);
    step(); if_req = 1'b0;

    // Randomized traffic with occasional resets and abandoned requests
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      seenIf = if_valid;
      seenDm = dm_valid;
      step();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      if (if_req) begin
        if (seenIf || $urandom_range(0, 99) == 0) if_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = 32'($urandom_range(0, 63)) << 2;
      end
      if (dm_req) begin
        if (seenDm || $urandom_range(0, 99) == 0) dm_req = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        dm_req   = 1'b1;
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = 32'($urandom_range(0, 63)) << 2;
        dm_wdata = $urandom;
      end
    end
    reset = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    repeat (10) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
